// File: rtl/wb_burst_sram_slave_pkg.sv
// Shared definitions for the Wishbone burst slave and its neighbours
// (cache and arbiter burst ports reuse the data/sel widths and BL default).
package wb_burst_sram_slave_pkg;
  localparam int BL_WIDTH_DEF = 10;
  localparam int DAT_W        = 32;
  localparam int SEL_W        = DAT_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;
endpackage

// File: rtl/wb_burst_cnt.sv
// Burst beat counter / word-address incrementer.
// Ports:
//   clk, rst_i      clock, synchronous active-high reset
//   load_i          capture start address and beat count
//   addr_i, cnt_i   start word address and beat count to load
//   step_i          one beat done: address+1 (wrapping), count-1
//   addr_o          current word address
//   addr_nxt_o      current address + 1, modulo 2^AW
//   cnt_o           beats remaining
//   last_o          current beat is the final one
module wb_burst_cnt #(
  parameter int AW = 10,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] addr_nxt_o,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = cnt_i;
    end else if (step_i) begin
      addr_d = addr_nxt_o;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Natural overflow of the AW-bit sum gives the window wrap.
  assign addr_nxt_o = addr_q + AW'(1);
  assign addr_o     = addr_q;
  assign cnt_o      = cnt_q;
  assign last_o     = (cnt_q == CW'(1));
endmodule

// File: rtl/wb_burst_sram_slave.sv
// Wishbone burst responder in front of a single-port SRAM with 1-cycle read
// latency. Streams one beat per cycle while the master holds bry.
// Ports:
//   clk, wb_rst_i           clock, synchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat/bl/bry_i   Wishbone burst request side
//   wbs_ack_o, wbs_dat_o    beat complete, read data (straight from SRAM)
//   busy_o                  a burst is in progress (state != IDLE)
//   sram_*                  SRAM macro port (csb/web active-low)
module wb_burst_sram_slave
  import wb_burst_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BL_WIDTH   = BL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [SEL_W-1:0]      wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DAT_W-1:0]      wbs_dat_i,
  input  logic [BL_WIDTH-1:0]   wbs_bl_i,
  input  logic                  wbs_bry_i,
  output logic                  wbs_ack_o,
  output logic [DAT_W-1:0]      wbs_dat_o,
  output logic                  busy_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [SEL_W-1:0]      sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DAT_W-1:0]      sram_din0,
  input  logic [DAT_W-1:0]      sram_dout0
);
  wb_state_e             state_q;
  logic [ADDR_WIDTH-1:0] adr_word, addr_q, addr_nxt;
  logic [BL_WIDTH-1:0]   bl_eff, cnt_q;
  logic                  last, load, step;
  logic                  unused_adr;

  assign adr_word   = wbs_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0], cnt_q};
  assign bl_eff     = (wbs_bl_i == '0) ? BL_WIDTH'(1) : wbs_bl_i;

  wb_burst_cnt #(.AW(ADDR_WIDTH), .CW(BL_WIDTH)) u_cnt (
    .clk        (clk),
    .rst_i      (wb_rst_i),
    .load_i     (load),
    .addr_i     (adr_word),
    .cnt_i      (bl_eff),
    .step_i     (step),
    .addr_o     (addr_q),
    .addr_nxt_o (addr_nxt),
    .cnt_o      (cnt_q),
    .last_o     (last)
  );

  // Bus handshake and SRAM port are combinational so a read issued on an
  // accepted beat lands on sram_dout0 in time for the next beat.
  // Reset gates everything so a dropped burst never touches the SRAM.
  always_comb begin
    wbs_ack_o   = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = addr_q;
    sram_din0   = '0;
    load        = 1'b0;
    step        = 1'b0;
    if (!wb_rst_i) begin
      unique case (state_q)
        ST_IDLE: if (wbs_cyc_i && wbs_stb_i) begin
          load = 1'b1;
          if (!wbs_we_i) begin
            sram_csb0  = 1'b0;
            sram_addr0 = adr_word;
          end
        end
        ST_RD: if (wbs_cyc_i && wbs_bry_i) begin
          wbs_ack_o = 1'b1;
          step      = 1'b1;
          // Prefetch the next word unless this is the final beat.
          if (!last) begin
            sram_csb0  = 1'b0;
            sram_addr0 = addr_nxt;
          end
        end
        ST_WR: if (wbs_cyc_i && wbs_bry_i) begin
          wbs_ack_o   = 1'b1;
          step        = 1'b1;
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = wbs_sel_i;
          sram_din0   = wbs_dat_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (wbs_cyc_i && wbs_stb_i)
                   state_q <= wbs_we_i ? ST_WR : ST_RD;
        ST_RD, ST_WR: begin
          if (!wbs_cyc_i)             state_q <= ST_IDLE;
          else if (wbs_bry_i && last) state_q <= ST_DONE;
        end
        // Hold here while the master keeps cyc so no second burst starts.
        ST_DONE: if (!wbs_cyc_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_dat_o = sram_dout0;
  assign busy_o    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_wb_burst_sram_slave.sv
module tb_wb_burst_sram_slave;
  localparam int AW = 10;
  localparam int BW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we, bry;
  logic [3:0]    sel;
  logic [31:0]   adr, dat;
  logic [BW-1:0] bl;
  logic          ack, busy, csb, web;
  logic [31:0]   dat_o, din, dout;
  logic [3:0]    wmask;
  logic [AW-1:0] saddr;

  always #5 clk = ~clk;

  wb_burst_sram_slave #(.ADDR_WIDTH(AW), .BL_WIDTH(BW)) dut (
    .clk(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_bl_i(bl),
    .wbs_bry_i(bry), .wbs_ack_o(ack), .wbs_dat_o(dat_o), .busy_o(busy),
    .sram_csb0(csb), .sram_web0(web), .sram_wmask0(wmask), .sram_addr0(saddr),
    .sram_din0(din), .sram_dout0(dout)
  );

  // SRAM macro: 1-cycle read latency, output held when not selected.
  logic [31:0] sram_mem [N];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int k = 0; k < 4; k++)
          if (wmask[k]) sram_mem[saddr][8*k+:8] <= din[8*k+:8];
      end else begin
        dout <= sram_mem[saddr];
      end
    end
  end

  // Reference model: expected memory contents and per-cycle expectations.
  logic [31:0]   ref_mem [N];
  logic [31:0]   wbuf [64];
  logic          chk_en = 1'b0;
  logic          e_ack, e_busy, e_bchk, e_acc, e_web, e_dchk;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_wmask;
  logic [31:0]   e_din, e_dat;
  int            nvec = 0, nerr = 0, n_ack = 0, n_acc = 0;
  logic [31:0]   last_dat = '0;
  logic          pin_go = 1'b0;
  string         pin_nm;
  int            pin_act, pin_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    nvec++;
    if (act !== ex) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, ex, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pin_go) chk(pin_nm, 32'(pin_act), 32'(pin_exp));
    if (chk_en) begin
      chk("ack", 32'(ack), 32'(e_ack));
      if (e_bchk) chk("busy", 32'(busy), 32'(e_busy));
      chk("csb", 32'(csb), 32'(!e_acc));
      if (e_acc) begin
        chk("web", 32'(web), 32'(e_web));
        chk("addr", 32'(saddr), 32'(e_addr));
        if (!e_web) begin
          chk("wmask", 32'(wmask), 32'(e_wmask));
          chk("din", din, e_din);
        end
      end else begin
        chk("web_idle", 32'(web), 32'd1);
        chk("wmask_idle", 32'(wmask), 32'd0);
      end
      if (e_dchk) chk("rdata", dat_o, e_dat);
    end
    if (ack) begin
      n_ack    <= n_ack + 1;
      last_dat <= dat_o;
    end
    if (!csb) n_acc <= n_acc + 1;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_quiet(input logic b);
    e_ack = 0; e_busy = b; e_bchk = 1; e_acc = 0; e_dchk = 0;
  endtask

  task automatic idle();
    nxt();
    cyc = 0; stb = 0; bry = 1'($urandom); dat = $urandom;
    exp_quiet(0);
  endtask

  task automatic pin(input string nm, input int act, input int ex);
    pin_nm = nm; pin_act = act; pin_exp = ex; pin_go = 1;
    @(negedge clk);
    #1 pin_go = 0;
  endtask

  task automatic req(input int sw, input int bln, input logic w);
    nxt();
    rst = 0; cyc = 1; stb = 1; we = w; bry = 1'($urandom);
    adr = $urandom; adr[AW+1:2] = AW'(sw); bl = BW'(bln);
    exp_quiet(0);
  endtask

  // Read burst: pat bit i is bry in the i-th cycle after the request;
  // ab >= 0 drops cyc before beat index ab; hold = cycles cyc stays up
  // after the final beat.
  task automatic rd_burst(input int sw, input int bln, input logic [63:0] pat,
                          input int ab, input int hold);
    int n, b, i;
    bit abd;
    n = (bln == 0) ? 1 : bln; b = 0; i = 0; abd = 0;
    req(sw, bln, 0);
    e_acc = 1; e_web = 1; e_addr = AW'(sw);
    while (b < n) begin
      nxt(); i++;
      if (ab >= 0 && b == ab) begin
        cyc = 0; stb = 0; exp_quiet(1); abd = 1;
        break;
      end
      bry = (i <= 64) ? pat[i-1] : 1'b1;
      e_busy = 1; e_dchk = 1; e_dat = ref_mem[(sw + b) % N];
      if (bry) begin
        e_ack = 1;
        e_acc = (b + 1 < n);
        e_web = 1; e_addr = AW'(sw + b + 1);
        b++;
      end else begin
        e_ack = 0; e_acc = 0;
      end
    end
    if (!abd) begin
      repeat (hold) begin nxt(); bry = 1'($urandom); exp_quiet(1); end
      nxt(); cyc = 0; stb = 0; exp_quiet(1);
    end
  endtask

  task automatic wr_burst(input int sw, input int bln, input logic [3:0] s,
                          input logic [63:0] pat, input int ab, input int hold);
    int n, b, i, a;
    bit abd;
    n = (bln == 0) ? 1 : bln; b = 0; i = 0; abd = 0;
    req(sw, bln, 1);
    sel = s;
    while (b < n) begin
      nxt(); i++;
      if (ab >= 0 && b == ab) begin
        cyc = 0; stb = 0; exp_quiet(1); abd = 1;
        break;
      end
      bry = (i <= 64) ? pat[i-1] : 1'b1;
      dat = wbuf[b];
      exp_quiet(1);
      if (bry) begin
        a = (sw + b) % N;
        e_ack = 1; e_acc = 1; e_web = 0; e_addr = AW'(a); e_wmask = s; e_din = wbuf[b];
        for (int k = 0; k < 4; k++) if (s[k]) ref_mem[a][8*k+:8] = wbuf[b][8*k+:8];
        b++;
      end
    end
    if (!abd) begin
      repeat (hold) begin nxt(); bry = 1'($urandom); exp_quiet(1); end
      nxt(); cyc = 0; stb = 0; exp_quiet(1);
    end
  endtask

  task automatic rst_mid_wr(input int sw);
    req(sw, 8, 1);
    sel = 4'hF;
    nxt(); bry = 1; dat = $urandom;
    exp_quiet(1); e_ack = 1; e_acc = 1; e_web = 0; e_addr = AW'(sw); e_wmask = 4'hF; e_din = dat;
    ref_mem[sw % N] = dat;
    nxt(); rst = 1; dat = $urandom; exp_quiet(1); e_bchk = 0;
    nxt(); rst = 0; stb = 0; exp_quiet(0);
    nxt(); cyc = 0; exp_quiet(0);
  endtask

  initial begin
    int a0, c0, sw, bln, ab;
    logic [63:0] pat;
    for (int k = 0; k < N; k++) begin
      sram_mem[k] = $urandom;
      ref_mem[k]  = sram_mem[k];
    end
    for (int k = 0; k < 8; k++) begin
      sram_mem[16+k] = 32'hA0 + k; ref_mem[16+k] = 32'hA0 + k;
    end
    for (int k = 0; k < 4; k++) begin
      sram_mem[64+k] = 32'hABCD0000 | k; ref_mem[64+k] = 32'hABCD0000 | k;
    end
    rst = 1; cyc = 0; stb = 0; we = 0; bry = 0; sel = 0; adr = 0; dat = 0; bl = 0;
    e_addr = 0; e_wmask = 0; e_din = 0; e_dat = 0; e_web = 1;

    nxt(); chk_en = 1; exp_quiet(0); e_bchk = 0;
    nxt(); rst = 0; exp_quiet(0);

    // 1: 8-beat read, bry held
    a0 = n_ack; c0 = n_acc;
    rd_burst(16, 8, '1, -1, 2); idle();
    pin("t1_acks", n_ack - a0, 8);
    pin("t1_accesses", n_acc - c0, 8);
    pin("t1_last_data", int'(last_dat), 32'hA7);

    // 2: masked write with bry 1,0,1,1,0,1
    for (int k = 0; k < 4; k++) wbuf[k] = 32'h11111111 * (k + 1);
    a0 = n_ack;
    wr_burst(64, 4, 4'b0011, 64'h2D, -1, 0); idle();
    pin("t2_acks", n_ack - a0, 4);
    rd_burst(64, 4, '1, -1, 0); idle();
    pin("t2_word43", int'(last_dat), 32'hABCD4444);
    rd_burst(64, 1, '1, -1, 0); idle();
    pin("t2_word40", int'(last_dat), 32'hABCD1111);

    // 3: read stall after beat 1
    a0 = n_ack;
    rd_burst(128, 4, 64'hFFFF_FFFF_FFFF_FFF1, -1, 0); idle();
    pin("t3_acks", n_ack - a0, 4);

    // 4: abort after 5 beats, then reset mid-write
    a0 = n_ack; c0 = n_acc;
    rd_burst(512, 16, '1, 5, 0); idle(); idle();
    pin("t4_abort_acks", n_ack - a0, 5);
    pin("t4_abort_accesses", n_acc - c0, 6);
    rst_mid_wr(700); idle();

    // 5: bl = 0 and address wrap
    a0 = n_ack; c0 = n_acc;
    rd_burst(300, 0, '1, -1, 0); idle();
    pin("t5_bl0_acks", n_ack - a0, 1);
    pin("t5_bl0_accesses", n_acc - c0, 1);
    c0 = n_acc;
    rd_burst(N - 2, 4, '1, -1, 0); idle();
    pin("t5_wrap_accesses", n_acc - c0, 4);
    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    wr_burst(N - 1, 3, 4'hF, '1, -1, 0); idle();

    // 6: cyc held after last beat, one low cycle, then a new burst
    a0 = n_ack;
    rd_burst(40, 2, '1, -1, 3);
    rd_burst(41, 3, '1, -1, 0); idle();
    pin("t6_acks", n_ack - a0, 5);

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      sw  = $urandom_range(0, N - 1);
      bln = $urandom_range(0, 12);
      pat = {$urandom, $urandom} | {$urandom, $urandom};
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (bln == 0) ? 0 : bln - 1) : -1;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        wr_burst(sw, bln, 4'($urandom), pat, ab, $urandom_range(0, 2));
      end else begin
        rd_burst(sw, bln, pat, ab, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle(); idle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
